vanilla_bubble_profiler: RTL and testbench

- Successor to the vanilla EXE bubble classifier, generalised to a parametrised front-end pipe depth and cause count.
- Tracks front-end bubble causes through pipe_depth_p stages, merges them with ID-stage stall causes at EXE entry, and classifies every EXE bubble.
- Keeps a per-cause retired-bubble counter, saturating or wrapping.
- On request, snapshots all counters and streams them out over a valid/yumi handshake.
- Sits beside the vanilla core in testbench/profiling logic; it is purely observational.

---
 rtl/vanilla_bubble_profiler.sv | 213 +++++++++++++++++++++
 tb/tb_vanilla_bubble_profiler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_bubble_profiler.sv
// Classifies every EXE bubble of the vanilla core, counts retired bubbles per cause,
// and streams snapshots of the per-cause counters out over a valid/yumi port.

module vanilla_bubble_profiler #(
    parameter int unsigned  pc_width_p    = 32,
    parameter int unsigned  num_causes_p  = 16,
    parameter int unsigned  pipe_depth_p  = 2,
    parameter int unsigned  ctr_width_p   = 32,
    parameter bit           saturate_p    = 1'b1,
    localparam int unsigned type_width_lp = $clog2(num_causes_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     stall_all_i,

    input  logic [num_causes_p-1:0]  front_cause_v_i,
    input  logic [pc_width_p-1:0]    front_pc_i,
    input  logic                     redirect_i,
    input  logic [type_width_lp-1:0] redirect_cause_i,
    input  logic [pc_width_p-1:0]    redirect_pc_i,
    input  logic [num_causes_p-1:0]  stall_cause_v_i,
    input  logic [pc_width_p-1:0]    id_pc_i,

    output logic [type_width_lp-1:0] exe_bubble_type_o,
    output logic [pc_width_p-1:0]    exe_bubble_pc_o,

    input  logic                     snapshot_i,
    output logic                     rd_v_o,
    output logic [ctr_width_p-1:0]   rd_data_o,
    output logic [type_width_lp-1:0] rd_idx_o,
    output logic                     rd_last_o,
    input  logic                     rd_yumi_i,
    output logic                     snapshot_dropped_o
);

    localparam int unsigned idx_width_lp = (num_causes_p > 1) ? $clog2(num_causes_p) : 1;
    localparam logic [type_width_lp-1:0] NoBubble = type_width_lp'(num_causes_p);
    localparam logic [type_width_lp-1:0] LastIdx  = type_width_lp'(num_causes_p - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Lowest set index wins; an empty vector encodes as "no bubble".
    function automatic logic [type_width_lp-1:0] prio_enc(input logic [num_causes_p-1:0] v);
        logic [type_width_lp-1:0] r;
        r = NoBubble;
        for (int i = int'(num_causes_p) - 1; i >= 0; i--) begin
            if (v[i]) r = type_width_lp'(i);
        end
        return r;
    endfunction

    logic [type_width_lp-1:0] stage_type_q [pipe_depth_p];
    logic [type_width_lp-1:0] stage_type_d [pipe_depth_p];
    logic [pc_width_p-1:0]    stage_pc_q   [pipe_depth_p];
    logic [pc_width_p-1:0]    stage_pc_d   [pipe_depth_p];
    logic [type_width_lp-1:0] exe_type_q, exe_type_d;
    logic [pc_width_p-1:0]    exe_pc_q, exe_pc_d;

    logic [ctr_width_p-1:0]   ctr_q    [num_causes_p];
    logic [ctr_width_p-1:0]   ctr_d    [num_causes_p];
    logic [ctr_width_p-1:0]   shadow_q [num_causes_p];
    logic [ctr_width_p-1:0]   shadow_d [num_causes_p];

    state_e                   state_q, state_d;
    logic [type_width_lp-1:0] idx_q, idx_d;
    logic                     rd_v_q, rd_v_d;
    logic [ctr_width_p-1:0]   rd_data_q, rd_data_d;
    logic                     rd_last_q, rd_last_d;
    logic                     dropped_q, dropped_d;

    logic [type_width_lp-1:0] front_type;
    logic [type_width_lp-1:0] stall_type;
    logic [type_width_lp-1:0] idx_next;
    logic                     retire;

    assign front_type = prio_enc(front_cause_v_i);
    assign stall_type = prio_enc(stall_cause_v_i);
    assign idx_next   = idx_q + type_width_lp'(1);
    assign retire     = !stall_all_i && (exe_type_q != NoBubble);

    // Front-end bubble pipe and EXE-entry merge.
    always_comb begin
        stage_type_d = stage_type_q;
        stage_pc_d   = stage_pc_q;
        exe_type_d   = exe_type_q;
        exe_pc_d     = exe_pc_q;
        if (!stall_all_i) begin
            if (redirect_i) begin
                for (int k = 0; k < int'(pipe_depth_p); k++) begin
                    stage_type_d[k] = redirect_cause_i;
                    stage_pc_d[k]   = redirect_pc_i;
                end
                exe_type_d = redirect_cause_i;
                exe_pc_d   = redirect_pc_i;
            end else begin
                stage_type_d[0] = front_type;
                stage_pc_d[0]   = front_pc_i;
                for (int k = 1; k < int'(pipe_depth_p); k++) begin
                    stage_type_d[k] = stage_type_q[k-1];
                    stage_pc_d[k]   = stage_pc_q[k-1];
                end
                if (stage_type_q[pipe_depth_p-1] != NoBubble) begin
                    exe_type_d = stage_type_q[pipe_depth_p-1];
                    exe_pc_d   = stage_pc_q[pipe_depth_p-1];
                end else if (stall_type != NoBubble) begin
                    exe_type_d = stall_type;
                    exe_pc_d   = id_pc_i;
                end else begin
                    exe_type_d = NoBubble;
                    exe_pc_d   = '0;
                end
            end
        end
    end

    // Snapshot/read-out FSM and per-cause counters; a retiring bubble lands after any clear.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_v_d    = rd_v_q;
        rd_data_d = rd_data_q;
        rd_last_d = rd_last_q;
        dropped_d = dropped_q;
        shadow_d  = shadow_q;
        ctr_d     = ctr_q;

        case (state_q)
            IDLE: begin
                if (snapshot_i) begin
                    shadow_d = ctr_q;
                    for (int i = 0; i < int'(num_causes_p); i++) begin
                        ctr_d[i] = '0;
                    end
                    state_d   = STREAM;
                    idx_d     = '0;
                    rd_v_d    = 1'b1;
                    rd_data_d = ctr_q[0];
                    rd_last_d = (num_causes_p == 1);
                end
            end
            STREAM: begin
                if (snapshot_i) dropped_d = 1'b1;
                if (rd_yumi_i) begin
                    if (idx_q == LastIdx) begin
                        state_d   = IDLE;
                        idx_d     = '0;
                        rd_v_d    = 1'b0;
                        rd_last_d = 1'b0;
                    end else begin
                        idx_d     = idx_next;
                        rd_data_d = shadow_q[idx_width_lp'(idx_next)];
                        rd_last_d = (idx_next == LastIdx);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < int'(num_causes_p); i++) begin
            if (retire && (exe_type_q == type_width_lp'(i))) begin
                if (!(saturate_p && (ctr_d[i] == '1))) begin
                    ctr_d[i] = ctr_d[i] + ctr_width_p'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < int'(pipe_depth_p); k++) begin
                stage_type_q[k] <= NoBubble;
                stage_pc_q[k]   <= '0;
            end
            exe_type_q <= NoBubble;
            exe_pc_q   <= '0;
            for (int i = 0; i < int'(num_causes_p); i++) begin
                ctr_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            state_q   <= IDLE;
            idx_q     <= '0;
            rd_v_q    <= 1'b0;
            rd_data_q <= '0;
            rd_last_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            stage_type_q <= stage_type_d;
            stage_pc_q   <= stage_pc_d;
            exe_type_q   <= exe_type_d;
            exe_pc_q     <= exe_pc_d;
            ctr_q        <= ctr_d;
            shadow_q     <= shadow_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            rd_v_q       <= rd_v_d;
            rd_data_q    <= rd_data_d;
            rd_last_q    <= rd_last_d;
            dropped_q    <= dropped_d;
        end
    end

    assign exe_bubble_type_o  = exe_type_q;
    assign exe_bubble_pc_o    = exe_pc_q;
    assign rd_v_o             = rd_v_q;
    assign rd_data_o          = rd_data_q;
    assign rd_idx_o           = idx_q;
    assign rd_last_o          = rd_last_q;
    assign snapshot_dropped_o = dropped_q;

endmodule

// File: tb/tb_vanilla_bubble_profiler.sv
// Bench for vanilla_bubble_profiler: a saturating and a wrapping 4-bit-counter instance
// driven in parallel and compared against a cycle-history reference model.

module tb_vanilla_bubble_profiler;

    localparam int NC    = 16;
    localparam int PCW   = 32;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int TW    = 5;
    localparam int HN    = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic           stall_all;
    logic [NC-1:0]  front_v;
    logic [PCW-1:0] front_pc;
    logic           redirect;
    logic [TW-1:0]  redirect_cause;
    logic [PCW-1:0] redirect_pc;
    logic [NC-1:0]  stall_v;
    logic [PCW-1:0] id_pc;
    logic           snapshot;
    logic           yumi;

    logic [TW-1:0]  s_type, w_type;
    logic [PCW-1:0] s_pc, w_pc;
    logic           s_rv, w_rv, s_rlast, w_rlast, s_drop, w_drop;
    logic [CW-1:0]  s_rd, w_rd;
    logic [TW-1:0]  s_ridx, w_ridx;

    vanilla_bubble_profiler #(.pc_width_p(PCW), .num_causes_p(NC), .pipe_depth_p(DEPTH),
                              .ctr_width_p(CW), .saturate_p(1'b1)) u_sat (
        .clk_i(clk), .reset_n_i(reset_n), .stall_all_i(stall_all),
        .front_cause_v_i(front_v), .front_pc_i(front_pc),
        .redirect_i(redirect), .redirect_cause_i(redirect_cause), .redirect_pc_i(redirect_pc),
        .stall_cause_v_i(stall_v), .id_pc_i(id_pc),
        .exe_bubble_type_o(s_type), .exe_bubble_pc_o(s_pc),
        .snapshot_i(snapshot), .rd_v_o(s_rv), .rd_data_o(s_rd), .rd_idx_o(s_ridx),
        .rd_last_o(s_rlast), .rd_yumi_i(yumi), .snapshot_dropped_o(s_drop)
    );

    vanilla_bubble_profiler #(.pc_width_p(PCW), .num_causes_p(NC), .pipe_depth_p(DEPTH),
                              .ctr_width_p(CW), .saturate_p(1'b0)) u_wrap (
        .clk_i(clk), .reset_n_i(reset_n), .stall_all_i(stall_all),
        .front_cause_v_i(front_v), .front_pc_i(front_pc),
        .redirect_i(redirect), .redirect_cause_i(redirect_cause), .redirect_pc_i(redirect_pc),
        .stall_cause_v_i(stall_v), .id_pc_i(id_pc),
        .exe_bubble_type_o(w_type), .exe_bubble_pc_o(w_pc),
        .snapshot_i(snapshot), .rd_v_o(w_rv), .rd_data_o(w_rd), .rd_idx_o(w_ridx),
        .rd_last_o(w_rlast), .rd_yumi_i(yumi), .snapshot_dropped_o(w_drop)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per un-stalled-cycle history of what entered the front end.
    int             hist_type  [HN];
    logic [PCW-1:0] hist_pc    [HN];
    bit             hist_redir [HN];
    int             n;
    int             m_type;
    logic [PCW-1:0] m_pc;
    int             cnt    [NC];
    int             shadow [NC];
    bit             streaming;
    int             ridx;
    bit             dropped;

    function automatic int lowest(input logic [NC-1:0] v);
        logic [NC-1:0] iso;
        if (v == '0) return NC;
        iso = v & (~v + NC'(1));
        return $clog2(iso);
    endfunction

    function automatic int satv(input int c, input bit sat);
        int top;
        top = (1 << CW) - 1;
        if (sat) return (c > top) ? top : c;
        return c % (1 << CW);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = DEPTH;
        for (int k = 0; k <= DEPTH; k++) begin
            hist_type[k]  = NC;
            hist_pc[k]    = '0;
            hist_redir[k] = 1'b0;
        end
        m_type = NC;
        m_pc   = '0;
        for (int i = 0; i < NC; i++) begin
            cnt[i]    = 0;
            shadow[i] = 0;
        end
        streaming = 1'b0;
        ridx      = 0;
        dropped   = 1'b0;
    endtask

    task automatic model_edge();
        bit inc, was_stream;
        int inc_t, latest, lt, nn;
        logic [PCW-1:0] lp;
        inc        = !stall_all && (m_type != NC);
        inc_t      = m_type;
        was_stream = streaming;
        if (!was_stream && snapshot) begin
            for (int i = 0; i < NC; i++) begin
                shadow[i] = cnt[i];
                cnt[i]    = 0;
            end
            streaming = 1'b1;
            ridx      = 0;
        end else if (was_stream && snapshot) begin
            dropped = 1'b1;
        end
        if (inc) cnt[inc_t]++;
        if (was_stream && yumi) begin
            if (ridx == NC - 1) begin
                streaming = 1'b0;
                ridx      = 0;
            end else begin
                ridx++;
            end
        end
        if (!stall_all) begin
            nn = n + 1;
            if (redirect) begin
                m_type = int'(redirect_cause);
                m_pc   = redirect_pc;
            end else begin
                latest = -1;
                for (int m = nn - DEPTH; m < nn; m++) begin
                    if (hist_redir[m % HN]) latest = m;
                end
                if (latest < 0) latest = nn - DEPTH;
                lt = hist_type[latest % HN];
                lp = hist_pc[latest % HN];
                if (lt != NC) begin
                    m_type = lt;
                    m_pc   = lp;
                end else if (lowest(stall_v) != NC) begin
                    m_type = lowest(stall_v);
                    m_pc   = id_pc;
                end else begin
                    m_type = NC;
                    m_pc   = '0;
                end
            end
            hist_redir[nn % HN] = redirect;
            hist_type[nn % HN]  = redirect ? int'(redirect_cause) : lowest(front_v);
            hist_pc[nn % HN]    = redirect ? redirect_pc : front_pc;
            n = nn;
        end
    endtask

    task automatic check_all();
        chk("exe_type_sat", 64'(s_type), 64'(m_type));
        chk("exe_type_wrap", 64'(w_type), 64'(m_type));
        chk("exe_pc_sat", 64'(s_pc), 64'(m_pc));
        chk("exe_pc_wrap", 64'(w_pc), 64'(m_pc));
        chk("rd_v_sat", 64'(s_rv), 64'(streaming));
        chk("rd_v_wrap", 64'(w_rv), 64'(streaming));
        chk("dropped_sat", 64'(s_drop), 64'(dropped));
        chk("dropped_wrap", 64'(w_drop), 64'(dropped));
        if (streaming) begin
            chk("rd_idx", 64'(s_ridx), 64'(ridx));
            chk("rd_idx_wrap", 64'(w_ridx), 64'(ridx));
            chk("rd_last", 64'(s_rlast), 64'(ridx == NC - 1));
            chk("rd_data_sat", 64'(s_rd), 64'(satv(shadow[ridx], 1'b1)));
            chk("rd_data_wrap", 64'(w_rd), 64'(satv(shadow[ridx], 1'b0)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic drain(input int cause, input int s_exp, input int w_exp);
        for (int i = 0; i < NC + 1 && streaming; i++) begin
            if (ridx == cause) begin
                chk("word_sat", 64'(s_rd), 64'(s_exp));
                chk("word_wrap", 64'(w_rd), 64'(w_exp));
            end
            if (ridx == NC - 1) chk("last_flag", 64'(s_rlast), 64'(1));
            else chk("not_last", 64'(s_rlast), 64'(0));
            yumi = 1'b1;
            step();
            yumi = 1'b0;
        end
        chk("stream_done", 64'(s_rv), 64'(0));
    endtask

    initial begin
        reset_n = 1'b0; stall_all = 1'b0; front_v = '0; front_pc = '0;
        redirect = 1'b0; redirect_cause = '0; redirect_pc = '0;
        stall_v = '0; id_pc = '0; snapshot = 1'b0; yumi = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_type", 64'(s_type), 64'(NC));
        chk("rst_pc", 64'(s_pc), 64'(0));
        chk("rst_rv", 64'(s_rv), 64'(0));
        chk("rst_drop", 64'(s_drop), 64'(0));
        reset_n = 1'b1;

        // Front bubble takes three un-stalled cycles to reach EXE.
        front_v = 16'h0004; front_pc = 32'h100;
        step();
        front_v = '0; front_pc = '0;
        step();
        step();
        chk("lat_type", 64'(s_type), 64'(2));
        chk("lat_pc", 64'(s_pc), 64'h100);
        step();
        chk("lat_gone", 64'(s_type), 64'(NC));

        stall_v = 16'h0030; id_pc = 32'h200;
        step();
        chk("stall_type", 64'(s_type), 64'(4));
        chk("stall_pc", 64'(s_pc), 64'h200);
        stall_v = '0; front_v = 16'h0004; front_pc = 32'h110;
        step();
        front_v = '0;
        step();
        stall_v = 16'h0030;
        step();
        chk("front_wins_type", 64'(s_type), 64'(2));
        chk("front_wins_pc", 64'(s_pc), 64'h110);
        stall_v = '0;
        step();

        // Redirect flushes a cause-5 bubble sitting in stage 0.
        front_v = 16'h0020; front_pc = 32'h120;
        step();
        front_v = '0; redirect = 1'b1; redirect_cause = '0; redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        chk("redir_0", 64'(s_type), 64'(0));
        step();
        chk("redir_1", 64'(s_type), 64'(0));
        step();
        chk("redir_2", 64'(s_type), 64'(0));
        step();
        chk("redir_end", 64'(s_type), 64'(NC));
        redirect_pc = '0;

        // Freeze with a cause-3 bubble in EXE.
        front_v = 16'h0008; front_pc = 32'h130;
        step();
        front_v = '0;
        step();
        step();
        chk("frz_pre", 64'(s_type), 64'(3));
        stall_all = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_type", 64'(s_type), 64'(3));
            chk("frz_pc", 64'(s_pc), 64'h130);
        end
        stall_all = 1'b0;
        step();
        chk("frz_post", 64'(s_type), 64'(NC));

        // 20 cause-1 bubbles: 15 when saturating, 4 when wrapping.
        stall_v = 16'h0002; id_pc = 32'h140;
        repeat (20) step();
        stall_v = '0;
        step();
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
        drain(1, 15, 4);

        // 7 cause-6 bubbles, held stream, dropped second snapshot.
        stall_v = 16'h0040;
        repeat (7) step();
        stall_v = '0;
        step();
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_idx", 64'(s_ridx), 64'(0));
            chk("hold_rv", 64'(s_rv), 64'(1));
        end
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
        chk("drop_sat", 64'(s_drop), 64'(1));
        chk("drop_wrap", 64'(w_drop), 64'(1));
        drain(6, 7, 7);

        // Asynchronous reset in the middle of a stream.
        stall_v = 16'h0001;
        repeat (3) step();
        stall_v = '0;
        step();
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
        yumi = 1'b1;
        step();
        step();
        yumi = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rv_sat", 64'(s_rv), 64'(0));
        chk("async_rv_wrap", 64'(w_rv), 64'(0));
        model_reset();
        step();
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) front_v = NC'(1 << $urandom_range(0, NC - 1));
            else if (r < 4) front_v = NC'($urandom);
            else front_v = '0;
            front_pc       = $urandom;
            redirect       = ($urandom_range(0, 19) == 0);
            redirect_cause = TW'($urandom_range(0, NC - 1));
            redirect_pc    = $urandom;
            stall_all      = ($urandom_range(0, 6) == 0);
            stall_v        = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            id_pc          = $urandom;
            snapshot       = ($urandom_range(0, 39) == 0);
            yumi           = streaming && ($urandom_range(0, 9) < 6);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
